// File: rtl/snake_pkg.sv
// Shared snake-game grid geometry and coordinate types.
// Used by the food spawner, occupancy memory and renderer.
package snake_pkg;

    localparam int unsigned GRID_W = 40;
    localparam int unsigned GRID_H = 30;
    localparam int unsigned X_BITS = 6;
    localparam int unsigned Y_BITS = 5;

    typedef logic [X_BITS-1:0] coord_x_t;
    typedef logic [Y_BITS-1:0] coord_y_t;

    typedef struct packed {
        coord_x_t x;
        coord_y_t y;
    } cell_t;

endpackage

// File: rtl/grid_raster_counter.sv
// x-first raster position over the grid, with clear, enable and last-cell flag.
module grid_raster_counter
    import snake_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    output logic [X_BITS-1:0] x,
    output logic [Y_BITS-1:0] y,
    output logic              last_c
);

    logic x_wrap;

    assign x_wrap = (x == X_BITS'(GRID_W - 1));
    assign last_c = x_wrap && (y == Y_BITS'(GRID_H - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x_wrap) begin
                x <= '0;
                y <= last_c ? '0 : y + Y_BITS'(1);
            end else begin
                x <= x + X_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/food_spawner.sv
// Picks a free food cell: bounded random draws from the LFSR word,
// then a raster scan fallback that reports failure on a full board.
module food_spawner
    import snake_pkg::*;
#(
    parameter int unsigned Y_LSB     = 8,
    parameter int unsigned MAX_TRIES = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       rnd,
    input  logic              spawn_req,
    output logic              busy,
    output logic              occ_rd,
    output logic [X_BITS-1:0] occ_x,
    output logic [Y_BITS-1:0] occ_y,
    input  logic              occ_hit,
    output logic [X_BITS-1:0] food_x,
    output logic [Y_BITS-1:0] food_y,
    output logic              food_valid,
    output logic              spawn_done,
    output logic              spawn_fail
);

    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

    typedef enum logic [1:0] {IDLE, DRAW, QUERY, CHECK} state_t;

    state_t            state, state_nxt;
    coord_x_t          cand_x, cand_x_nxt;
    coord_y_t          cand_y, cand_y_nxt;
    logic [TRY_W-1:0]  tries, tries_nxt, tries_inc;
    logic              scan, scan_nxt;
    coord_x_t          food_x_nxt;
    coord_y_t          food_y_nxt;
    logic              food_valid_nxt, spawn_done_nxt, spawn_fail_nxt;
    logic              scan_clr, scan_en, scan_last;
    coord_x_t          scan_x, rnd_x, qx;
    coord_y_t          scan_y, rnd_y, qy;
    logic              unused_rnd;

    assign rnd_x      = rnd[X_BITS-1:0];
    assign rnd_y      = rnd[Y_LSB +: Y_BITS];
    assign unused_rnd = ^{rnd[15:Y_LSB+Y_BITS], rnd[Y_LSB-1:X_BITS]};
    assign tries_inc  = tries + TRY_W'(1);

    // Queried cell: candidate in random mode, raster position in scan mode.
    assign qx     = scan ? scan_x : cand_x;
    assign qy     = scan ? scan_y : cand_y;
    assign busy   = (state != IDLE);
    assign occ_rd = (state == QUERY);
    assign occ_x  = occ_rd ? qx : '0;
    assign occ_y  = occ_rd ? qy : '0;

    grid_raster_counter u_scan (
        .clk    (clk),
        .reset  (reset),
        .clear  (scan_clr),
        .en     (scan_en),
        .x      (scan_x),
        .y      (scan_y),
        .last_c (scan_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cand_x     <= '0;
            cand_y     <= '0;
            tries      <= '0;
            scan       <= 1'b0;
            food_x     <= '0;
            food_y     <= '0;
            food_valid <= 1'b0;
            spawn_done <= 1'b0;
            spawn_fail <= 1'b0;
        end else begin
            state      <= state_nxt;
            cand_x     <= cand_x_nxt;
            cand_y     <= cand_y_nxt;
            tries      <= tries_nxt;
            scan       <= scan_nxt;
            food_x     <= food_x_nxt;
            food_y     <= food_y_nxt;
            food_valid <= food_valid_nxt;
            spawn_done <= spawn_done_nxt;
            spawn_fail <= spawn_fail_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cand_x_nxt     = cand_x;
        cand_y_nxt     = cand_y;
        tries_nxt      = tries;
        scan_nxt       = scan;
        food_x_nxt     = food_x;
        food_y_nxt     = food_y;
        food_valid_nxt = food_valid;
        spawn_done_nxt = 1'b0;
        spawn_fail_nxt = 1'b0;
        scan_clr       = 1'b0;
        scan_en        = 1'b0;

        case (state)
            IDLE: begin
                if (spawn_req) begin
                    food_valid_nxt = 1'b0;
                    tries_nxt      = '0;
                    scan_nxt       = 1'b0;
                    state_nxt      = DRAW;
                end
            end
            DRAW: begin
                cand_x_nxt = rnd_x;
                cand_y_nxt = rnd_y;
                if ((rnd_x < X_BITS'(GRID_W)) && (rnd_y < Y_BITS'(GRID_H))) begin
                    state_nxt = QUERY;
                end else begin
                    tries_nxt = tries_inc;
                    if (tries_inc == TRY_W'(MAX_TRIES)) begin
                        scan_nxt  = 1'b1;
                        scan_clr  = 1'b1;
                        state_nxt = QUERY;
                    end
                end
            end
            QUERY: state_nxt = CHECK;
            CHECK: begin
                if (!occ_hit) begin
                    food_x_nxt     = qx;
                    food_y_nxt     = qy;
                    food_valid_nxt = 1'b1;
                    spawn_done_nxt = 1'b1;
                    state_nxt      = IDLE;
                end else if (!scan) begin
                    tries_nxt = tries_inc;
                    if (tries_inc == TRY_W'(MAX_TRIES)) begin
                        scan_nxt  = 1'b1;
                        scan_clr  = 1'b1;
                        state_nxt = QUERY;
                    end else begin
                        state_nxt = DRAW;
                    end
                end else if (scan_last) begin
                    spawn_fail_nxt = 1'b1;
                    state_nxt      = IDLE;
                end else begin
                    scan_en   = 1'b1;
                    state_nxt = QUERY;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_food_spawner.sv
// Directed bench for food_spawner with a one-cycle-latency occupancy memory model.
module tb_food_spawner;
    import snake_pkg::*;

    logic              clk;
    logic              reset;
    logic [15:0]       rnd;
    logic              spawn_req;
    logic              busy;
    logic              occ_rd;
    logic [X_BITS-1:0] occ_x;
    logic [Y_BITS-1:0] occ_y;
    logic              occ_hit;
    logic [X_BITS-1:0] food_x;
    logic [Y_BITS-1:0] food_y;
    logic              food_valid;
    logic              spawn_done;
    logic              spawn_fail;

    int n_checks = 0;
    int n_errors = 0;
    int n_rd     = 0;
    logic occ_mem [0:63][0:31];

    food_spawner dut (
        .clk        (clk),
        .reset      (reset),
        .rnd        (rnd),
        .spawn_req  (spawn_req),
        .busy       (busy),
        .occ_rd     (occ_rd),
        .occ_x      (occ_x),
        .occ_y      (occ_y),
        .occ_hit    (occ_hit),
        .food_x     (food_x),
        .food_y     (food_y),
        .food_valid (food_valid),
        .spawn_done (spawn_done),
        .spawn_fail (spawn_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Occupancy memory: hit returned one cycle after the read strobe.
    always @(posedge clk) begin
        occ_hit <= occ_rd && occ_mem[occ_x][occ_y];
        if (occ_rd) n_rd <= n_rd + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_all(input logic v);
        for (int x = 0; x < 64; x++)
            for (int y = 0; y < 32; y++)
                occ_mem[x][y] = v;
    endtask

    // Steps until a done/fail pulse; n = cycles taken, -1 if budget expired.
    task automatic wait_pulse(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (spawn_done || spawn_fail) begin
                n = i;
                break;
            end
        end
    endtask

    int n, rd0;

    initial begin
        reset = 1'b1; spawn_req = 1'b0; rnd = 16'h0000;
        set_all(1'b0);
        step(); step(); step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(food_valid), 0);
        chk("rst_occ_rd", 32'(occ_rd), 0);
        chk("rst_food", 32'({food_x, food_y}), 0);
        reset = 1'b0;
        step();

        // Best case: (5,3) free
        rnd = 16'h0305; spawn_req = 1'b1;
        step(); spawn_req = 1'b0;
        chk("t1_busy", 32'(busy), 1);
        chk("t1_rd_a1", 32'(occ_rd), 0);
        step();
        chk("t1_rd_a2", 32'(occ_rd), 1);
        chk("t1_q", 32'({occ_x, occ_y}), 32'({6'd5, 5'd3}));
        step();
        chk("t1_done_a3", 32'(spawn_done), 0);
        step();
        chk("t1_done_a4", 32'(spawn_done), 1);
        chk("t1_busy_a4", 32'(busy), 0);
        chk("t1_valid", 32'(food_valid), 1);
        chk("t1_food", 32'({food_x, food_y}), 32'({6'd5, 5'd3}));
        step();
        chk("t1_pulse_len", 32'(spawn_done), 0);

        // One out-of-range draw, then (7,10)
        rnd = 16'h1F3F; spawn_req = 1'b1;
        step(); spawn_req = 1'b0;
        chk("t2_valid_clr", 32'(food_valid), 0);
        step(); rnd = 16'h0A07;
        chk("t2_rd_a2", 32'(occ_rd), 0);
        step();
        chk("t2_q", 32'({occ_rd, occ_x, occ_y}), 32'({1'b1, 6'd7, 5'd10}));
        step();
        chk("t2_done_a4", 32'(spawn_done), 0);
        step();
        chk("t2_done_a5", 32'(spawn_done), 1);
        chk("t2_food", 32'({food_x, food_y}), 32'({6'd7, 5'd10}));

        // (7,10) occupied, then (2,2)
        occ_mem[7][10] = 1'b1;
        rd0 = n_rd; rnd = 16'h0A07; spawn_req = 1'b1;
        step(); spawn_req = 1'b0;
        step(); rnd = 16'h0202;
        chk("t3_q1", 32'({occ_x, occ_y}), 32'({6'd7, 5'd10}));
        step(); step(); step();
        chk("t3_q2", 32'({occ_rd, occ_x, occ_y}), 32'({1'b1, 6'd2, 5'd2}));
        step(); step();
        chk("t3_done_a7", 32'(spawn_done), 1);
        chk("t3_food", 32'({food_x, food_y}), 32'({6'd2, 5'd2}));
        chk("t3_reads", 32'(n_rd - rd0), 2);

        // Request in the done cycle is accepted; (5,3) still free
        rnd = 16'h0305; spawn_req = 1'b1;
        step(); spawn_req = 1'b0;
        chk("t4_busy", 32'(busy), 1);
        chk("t4_valid_clr", 32'(food_valid), 0);
        wait_pulse(20, n);
        chk("t4_lat", 32'(n), 3);
        chk("t4_food", 32'({food_valid, food_x, food_y}), 32'({1'b1, 6'd5, 5'd3}));
        step();

        // Fallback: only (3,0) free, rnd stuck on occupied (7,10)
        set_all(1'b1); occ_mem[3][0] = 1'b0;
        rd0 = n_rd; rnd = 16'h0A07; spawn_req = 1'b1;
        for (int i = 1; i <= 97; i++) begin
            step(); spawn_req = 1'b0;
            if (i == 95) chk("t5_last_rand", 32'({occ_rd, occ_x, occ_y}), 32'({1'b1, 6'd7, 5'd10}));
            if (i == 97) chk("t5_scan0", 32'({occ_rd, occ_x, occ_y}), 32'({1'b1, 6'd0, 5'd0}));
        end
        wait_pulse(50, n);
        chk("t5_lat", 32'(97 + n), 105);
        chk("t5_food", 32'({spawn_done, food_valid, food_x, food_y}), 32'({2'b11, 6'd3, 5'd0}));
        chk("t5_reads", 32'(n_rd - rd0), 36);
        step();

        // Full board: fail at worst-case latency
        set_all(1'b1);
        spawn_req = 1'b1;
        step(); spawn_req = 1'b0;
        wait_pulse(3000, n);
        chk("t6_lat", 32'(1 + n), 2497);
        chk("t6_pulse", 32'({spawn_fail, spawn_done, food_valid}), 32'({3'b100}));
        chk("t6_busy", 32'(busy), 0);
        step();
        chk("t6_fail_len", 32'(spawn_fail), 0);

        // Reset in CHECK, then cold-start spawn
        set_all(1'b0);
        rnd = 16'h0305; spawn_req = 1'b1;
        step(); spawn_req = 1'b0;
        step(); step();
        reset = 1'b1;
        step(); reset = 1'b0;
        chk("t7_busy", 32'(busy), 0);
        chk("t7_outs", 32'({occ_rd, occ_x, occ_y, spawn_done, spawn_fail, food_valid}), 0);
        chk("t7_food", 32'({food_x, food_y}), 0);
        rnd = 16'h0A07; spawn_req = 1'b1;
        step(); spawn_req = 1'b0;
        wait_pulse(20, n);
        chk("t7_lat", 32'(1 + n), 4);
        chk("t7_food2", 32'({spawn_done, food_valid, food_x, food_y}), 32'({2'b11, 6'd7, 5'd10}));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
